pipeline_alu: RTL and testbench
===============================

// Module: pipeline_alu
// PURPOSE
//   Registered integer ALU for the EXE stage of the 16-bit pipelined processor.
//   Takes operand A (register value) and operand B (register value or immediate; the
//   EXE stage selects which). Computes AND/ADD/SUB/OR per ALUop.
//   Registers the result and status flags on clk; feeds EXE/MEM.
// PARAMETERS
//   WIDTH     16   datapath width in bits (all operand/result widths track it)
// PORTS
//   clk       in   1        single clock, rising edge
//   reset     in   1        synchronous, active-high reset
//   in_valid  in   1        operands/op valid this cycle
//   A         in   WIDTH    operand A, two's complement
//   B         in   WIDTH    operand B, two's complement (already muxed reg/imm)
//   ALUop     in   2        00=AND 01=ADD 10=SUB 11=OR
//   Output    out  WIDTH    registered result
//   out_valid out  1        Output/flags updated by previous cycle's in_valid
//   zero      out  1        registered: Output == 0
//   negative  out  1        registered: Output[WIDTH-1]
//   carry     out  1        registered: ADD carry-out / SUB borrow
//   overflow  out  1        registered: signed overflow (ADD/SUB only)
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high (reset); no async paths.
//   - Reset: on a rising edge with reset=1, Output=0, out_valid=0, zero=0, negative=0,
//     carry=0, overflow=0. Reset overrides in_valid in the same cycle.
//   - Latency is exactly 1 cycle.
//     in_valid=1 at edge N -> result/flags visible after edge N, out_valid=1.
//   - in_valid=0 at an edge: out_valid<=0. Output and flags hold previous values.
//   - No backpressure. A new operation may be accepted every cycle (throughput 1/clk).
//   - Arithmetic is modulo 2^WIDTH, two's complement; results wrap, never saturate.
//   - AND: A & B. OR: A | B. For both, carry=0 and overflow=0.
//   - ADD: {carry,Output} = A + B (WIDTH+1-bit unsigned sum).
//     overflow = A and B share a sign and the result sign differs.
//   - SUB: Output = A - B. carry = borrow = (A < B unsigned).
//     overflow = A and B differ in sign and the result sign differs from A's.
//   - zero/negative are derived from the value being registered into Output, every op.
//   - The ALUop decode is fully specified (11=OR). No X propagation from unused codes.
//   - Operands are sampled only at the edge. Input changes between edges have no effect
//     until the next edge.
// TESTING
//   1. A=15, B=0xFFF6(-10), ALUop=00, in_valid=1 -> next cycle Output=0x0006,
//      zero=0, neg=0, carry=0, ovf=0, out_valid=1.
//   2. Same operands, ALUop=01 -> Output=0x0005 (5), carry=1, ovf=0.
//      Then ALUop=10 -> Output=0x0019 (25), carry(borrow)=1, ovf=0.
//   3. A=15, B=5: ALUop=00 -> 5; 01 -> 20; 10 -> 10 (carry=0); 11 -> 15.
//      Each appears 1 cycle after issue with back-to-back in_valid.
//   4. A=0x7FFF, B=1, ADD -> Output=0x8000, ovf=1, neg=1, carry=0.
//      A=0x8000, B=1, SUB -> Output=0x7FFF, ovf=1.
//   5. A=5, B=5, SUB -> Output=0, zero=1, carry=0.
//      Then drop in_valid -> out_valid=0, Output stays 0.
//   6. Issue ADD with in_valid=1 and reset=1 on the same edge -> all outputs 0,
//      out_valid=0. After release, operation resumes normally.

Source files
------------

// File: rtl/pipeline_alu.sv
// Registered EXE-stage ALU: AND/ADD/SUB/OR with zero/negative/carry/overflow flags.
// One-cycle latency, one operation accepted per clock, no backpressure.
module pipeline_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUop,
    output logic [WIDTH-1:0] Output,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;
    logic             w_sign_a;
    logic             w_sign_b;

    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_zero;
    logic             r_negative;
    logic             r_carry;
    logic             r_overflow;

    // Widened arithmetic: the top bit of the difference is the unsigned borrow (A < B).
    always_comb begin
        w_sum    = {1'b0, A} + {1'b0, B};
        w_diff   = {1'b0, A} - {1'b0, B};
        w_sign_a = A[WIDTH-1];
        w_sign_b = B[WIDTH-1];
    end

    // Operation decode and flag generation for the value about to be registered.
    always_comb begin
        w_result   = {WIDTH{1'b0}};
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (ALUop)
            OP_AND: begin
                w_result   = A & B;
                w_carry    = 1'b0;
                w_overflow = 1'b0;
            end
            OP_ADD: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (w_sign_a == w_sign_b) && (w_sum[WIDTH-1] != w_sign_a);
            end
            OP_SUB: begin
                w_result   = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                w_overflow = (w_sign_a != w_sign_b) && (w_diff[WIDTH-1] != w_sign_a);
            end
            OP_OR: begin
                w_result   = A | B;
                w_carry    = 1'b0;
                w_overflow = 1'b0;
            end
            default: begin
                w_result   = {WIDTH{1'b0}};
                w_carry    = 1'b0;
                w_overflow = 1'b0;
            end
        endcase
    end

    // Result/flag register: reset wins over in_valid; idle cycles hold result and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= {WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (in_valid) begin
            r_result   <= w_result;
            r_valid    <= 1'b1;
            r_zero     <= (w_result == {WIDTH{1'b0}});
            r_negative <= w_result[WIDTH-1];
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
        end else begin
            r_valid    <= 1'b0;
        end
    end

    assign Output    = r_result;
    assign out_valid = r_valid;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pipeline_alu.sv
// Directed plus randomized scoreboard bench for pipeline_alu (WIDTH=16).
module tb_pipeline_alu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  ALUop;
    logic [15:0] Output;
    logic        out_valid;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        vld;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    int   checks;
    int   errors;

    pipeline_alu #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B), .ALUop(ALUop),
        .Output(Output), .out_valid(out_valid), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        exp_t e;
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        int sr;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        e  = '0;
        r  = 0;
        case (op)
            2'b00: r = ua & ub;
            2'b01: begin
                r   = ua + ub;
                e.c = (r > 65535);
                sr  = sa + sb;
                e.v = (sr > 32767) || (sr < -32768);
            end
            2'b10: begin
                r   = ua - ub;
                e.c = (ua < ub);
                sr  = sa - sb;
                e.v = (sr > 32767) || (sr < -32768);
            end
            default: r = ua | ub;
        endcase
        e.res = r[15:0];
        e.z   = (e.res == 16'h0000);
        e.n   = e.res[15];
        e.vld = 1'b1;
        return e;
    endfunction

    task automatic cmp1(input string tag, input string fld, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s got %h expected %h", tag, fld, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty got %h expected entry", tag, Output);
        end else begin
            e = q.pop_front();
            cmp1(tag, "valid", {15'd0, out_valid}, {15'd0, e.vld});
            cmp1(tag, "result", Output, e.res);
            cmp1(tag, "zero", {15'd0, zero}, {15'd0, e.z});
            cmp1(tag, "negative", {15'd0, negative}, {15'd0, e.n});
            cmp1(tag, "carry", {15'd0, carry}, {15'd0, e.c});
            cmp1(tag, "overflow", {15'd0, overflow}, {15'd0, e.v});
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, push expectation, check after the rising edge.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        A        = a;
        B        = b;
        ALUop    = op;
        if (rst) begin
            e = '0;
        end else if (v) begin
            e = model(a, b, op);
        end else begin
            e     = last_e;
            e.vld = 1'b0;
        end
        last_e = e;
        q.push_back(e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        A        = 16'h0000;
        B        = 16'h0000;
        ALUop    = 2'b00;
        checks   = 0;
        errors   = 0;
        last_e   = '0;

        step("reset0", 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00);
        step("reset1", 1'b1, 1'b1, 16'h1234, 16'h4321, 2'b01);

        step("t1_and", 1'b0, 1'b1, 16'd15, 16'hFFF6, 2'b00);
        step("t2_add", 1'b0, 1'b1, 16'd15, 16'hFFF6, 2'b01);
        step("t2_sub", 1'b0, 1'b1, 16'd15, 16'hFFF6, 2'b10);

        step("t3_and", 1'b0, 1'b1, 16'd15, 16'd5, 2'b00);
        step("t3_add", 1'b0, 1'b1, 16'd15, 16'd5, 2'b01);
        step("t3_sub", 1'b0, 1'b1, 16'd15, 16'd5, 2'b10);
        step("t3_or",  1'b0, 1'b1, 16'd15, 16'd5, 2'b11);

        step("t4_addovf", 1'b0, 1'b1, 16'h7FFF, 16'h0001, 2'b01);
        step("t4_subovf", 1'b0, 1'b1, 16'h8000, 16'h0001, 2'b10);
        step("addwrap",   1'b0, 1'b1, 16'hFFFF, 16'h0001, 2'b01);
        step("addnegovf", 1'b0, 1'b1, 16'h8000, 16'h8000, 2'b01);

        step("t5_subz",  1'b0, 1'b1, 16'd5, 16'd5, 2'b10);
        step("t5_idle",  1'b0, 1'b0, 16'hABCD, 16'h1234, 2'b11);
        step("t5_idle2", 1'b0, 1'b0, 16'h5555, 16'hAAAA, 2'b01);

        step("pre_rst", 1'b0, 1'b1, 16'h00F0, 16'h0F00, 2'b11);
        step("t6_rst",  1'b0 | 1'b1, 1'b1, 16'h7FFF, 16'h0001, 2'b01);
        step("t6_resume", 1'b0, 1'b1, 16'h0003, 16'h0004, 2'b01);

        for (int i = 0; i < 60; i++) begin
            step("rand", 1'b0, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
